cmp_event_tracker: RTL
======================

CMP_EVENT_TRACKER -- requirements
Module: cmp_event_tracker

Interface
REQ-001 SHALL have parameter STABLE_N, default 3: consecutive identical comparator samples needed to commit a relation; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 8: width of the crossing counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: GT/LT form a sample this cycle.
REQ-006 SHALL have port GT, input, 1: a>b flag from upstream comparator.
REQ-007 SHALL have port LT, input, 1: a<b flag from upstream comparator.
REQ-008 SHALL have port clr, input, 1: synchronous clear of cross_cnt, err and ev_lost.
REQ-009 SHALL have port ev_ready, input, 1: downstream accepts event.
REQ-010 SHALL have port rel_out, output, 2: committed relation; 00 NONE, 01 LT, 10 EQ, 11 GT.
REQ-011 SHALL have port ev_valid, output, 1: event pending.
REQ-012 SHALL have port ev_code, output, 2: relation of pending event, same encoding as rel_out.
REQ-013 SHALL have port cross_cnt, output, CNT_W: count of direct LT<->GT crossings.
REQ-014 SHALL have port err, output, 1: sticky; illegal sample (GT=LT=1) seen.
REQ-015 SHALL have port ev_lost, output, 1: sticky; pending event overwritten.

Function
REQ-016 SHALL decode each sample with in_valid=1 as GT=1,LT=0 -> GT; GT=0,LT=1 -> LT; GT=0,LT=0 -> EQ; GT=1,LT=1 -> illegal.
REQ-017 SHALL ignore cycles with in_valid=0 entirely: no state, run or counter change; gaps do not break a run.
REQ-018 SHALL on an illegal sample set err and otherwise leave FSM, run count and candidate unchanged.
REQ-019 SHALL implement FSM states IDLE (rel_out=NONE, no candidate), QUAL (candidate held, run count 1..STABLE_N-1) and STABLE (rel_out valid, no candidate).
REQ-020 SHALL in IDLE or STABLE, on a legal sample differing from rel_out, load candidate=sample and run=1 and go to QUAL; a sample equal to rel_out keeps the state.
REQ-021 SHALL in QUAL, on a sample equal to candidate, increment run; on a sample equal to rel_out (not NONE), drop the candidate and return to STABLE; otherwise reload candidate=sample, run=1.
REQ-022 SHALL commit when the sample completing run=STABLE_N is registered: at that edge rel_out<=candidate, FSM<=STABLE, an event with code=candidate is posted; with STABLE_N=1 the first differing sample commits directly.
REQ-023 SHALL give a commit latency of one clock: rel_out and ev_valid are visible the cycle after the edge registering the STABLE_N-th sample.
REQ-024 SHALL hold ev_valid until a transfer (ev_valid & ev_ready at an edge) and keep ev_code stable while ev_valid=1 without a new commit.
REQ-025 SHALL, on transfer and commit at the same edge, load the new event and keep ev_valid=1 without setting ev_lost.
REQ-026 SHALL, on commit while an event is pending without transfer, overwrite ev_code with the new code and set ev_lost.
REQ-027 SHALL track last_dir (last committed LT or GT, initially none; EQ commits do not change it) and increment cross_cnt on a commit of GT with last_dir=LT or LT with last_dir=GT.
REQ-028 SHALL saturate cross_cnt at all ones.
REQ-029 SHALL on clr=1 zero cross_cnt, err and ev_lost at that edge, taking priority over same-cycle set/increment, without affecting FSM, rel_out or events.

Reset
REQ-030 SHALL on reset=1 at an edge force IDLE, rel_out=00, ev_valid=0, ev_code=00, cross_cnt=0, err=0, ev_lost=0, run=0, last_dir=none, from any state including mid-QUAL with an event pending.
REQ-031 SHALL give reset priority over clr and all sample activity.

Verification (STABLE_N=3, CNT_W=8)
REQ-032 SHALL check: reset, then idle -> rel_out=00, ev_valid=0, cross_cnt=0, err=0, ev_lost=0.
REQ-033 SHALL check: a=5,b=2 (GT) valid 3 cycles with in_valid=0 gap between 2nd and 3rd -> rel_out=11, ev_valid=1, ev_code=11 one cycle after 3rd sample.
REQ-034 SHALL check: samples GT,GT,LT,GT,GT,GT from IDLE -> no commit until 6th sample; exactly one event, code 11.
REQ-035 SHALL check: ev_ready=1, LT x3 then GT x3 then EQ x3 then LT x3 -> events 01,11,10,01; cross_cnt=2.
REQ-036 SHALL check: ev_ready=0, LT x3 then GT x3 -> ev_code=11, ev_lost=1, ev_valid=1; then clr -> cross_cnt=0, ev_lost=0, ev_valid still 1.
REQ-037 SHALL check: GT x2, GT=LT=1, GT x1 -> err=1, commit GT on the 4th valid cycle; reset asserted mid-QUAL -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cmp_event_tracker.sv
// Qualifies a registered comparator's GT/LT flags into a debounced relation,
// posts one event per committed change, and counts direct LT<->GT crossings.
module cmp_event_tracker #(
    parameter int STABLE_N = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             GT,
    input  logic             LT,
    input  logic             clr,
    input  logic             ev_ready,
    output logic [1:0]       rel_out,
    output logic             ev_valid,
    output logic [1:0]       ev_code,
    output logic [CNT_W-1:0] cross_cnt,
    output logic             err,
    output logic             ev_lost
);

    // state  | meaning
    // IDLE   | nothing committed yet, rel_out = NONE, no candidate
    // QUAL   | candidate relation held, run count 1..STABLE_N-1
    // STABLE | rel_out holds a committed relation, no candidate
    typedef enum logic [1:0] {S_IDLE, S_QUAL, S_STABLE} state_t;

    localparam logic [1:0]       REL_NONE = 2'b00;
    localparam logic [1:0]       REL_LT   = 2'b01;
    localparam logic [1:0]       REL_EQ   = 2'b10;
    localparam logic [1:0]       REL_GT   = 2'b11;
    localparam logic [3:0]       RUN_LAST = 4'(STABLE_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    state_t           state_q, state_d;
    logic [1:0]       rel_q, rel_d;
    logic [1:0]       cand_q, cand_d;
    logic [3:0]       run_q, run_d;
    logic             ev_valid_q, ev_valid_d;
    logic [1:0]       ev_code_q, ev_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             lost_q, lost_d;
    logic [1:0]       last_q, last_d;

    logic [1:0] samp_code;
    logic       legal;
    logic       commit;
    logic       crossing;

    always_comb begin
        state_d   = state_q;
        rel_d     = rel_q;
        cand_d    = cand_q;
        run_d     = run_q;
        commit    = 1'b0;
        samp_code = GT ? REL_GT : (LT ? REL_LT : REL_EQ);
        legal     = in_valid & ~(GT & LT);

        if (legal) begin
            case (state_q)
                S_IDLE, S_STABLE: begin
                    if (samp_code != rel_q) begin
                        if (STABLE_N == 1) begin
                            commit = 1'b1;
                        end else begin
                            cand_d  = samp_code;
                            run_d   = 4'd1;
                            state_d = S_QUAL;
                        end
                    end
                end
                S_QUAL: begin
                    if (samp_code == cand_q) begin
                        if (run_q == RUN_LAST) commit = 1'b1;
                        else                   run_d  = run_q + 4'd1;
                    end else if (rel_q != REL_NONE && samp_code == rel_q) begin
                        // Glitch back to the committed relation: abandon candidate
                        state_d = S_STABLE;
                        cand_d  = REL_NONE;
                        run_d   = 4'd0;
                    end else begin
                        cand_d = samp_code;
                        run_d  = 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (commit) begin
            rel_d   = samp_code;
            state_d = S_STABLE;
            cand_d  = REL_NONE;
            run_d   = 4'd0;
        end
    end

    always_comb begin
        ev_valid_d = ev_valid_q & ~ev_ready;
        ev_code_d  = ev_code_q;
        lost_d     = lost_q;
        if (commit) begin
            ev_valid_d = 1'b1;
            ev_code_d  = samp_code;
            lost_d     = lost_q | (ev_valid_q & ~ev_ready);
        end

        crossing = commit & (((samp_code == REL_GT) && (last_q == REL_LT)) ||
                             ((samp_code == REL_LT) && (last_q == REL_GT)));
        last_d   = (commit && (samp_code == REL_GT || samp_code == REL_LT)) ? samp_code : last_q;

        cnt_d = cnt_q;
        if (crossing && cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
        err_d = err_q | (in_valid & GT & LT);

        // Clear wins over any same-cycle set or increment
        if (clr) begin
            cnt_d  = '0;
            err_d  = 1'b0;
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rel_q      <= REL_NONE;
            cand_q     <= REL_NONE;
            run_q      <= 4'd0;
            ev_valid_q <= 1'b0;
            ev_code_q  <= REL_NONE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            lost_q     <= 1'b0;
            last_q     <= REL_NONE;
        end else begin
            state_q    <= state_d;
            rel_q      <= rel_d;
            cand_q     <= cand_d;
            run_q      <= run_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            lost_q     <= lost_d;
            last_q     <= last_d;
        end
    end

    assign rel_out   = rel_q;
    assign ev_valid  = ev_valid_q;
    assign ev_code   = ev_code_q;
    assign cross_cnt = cnt_q;
    assign err       = err_q;
    assign ev_lost   = lost_q;

endmodule
